sm_cache_mesi: RTL

- Parametrised per-cache coherence controller: a direct-mapped array of LINES lines, each with a tag and a MESI state.
- Replaces the single-block MSI state machine and adds the Exclusive state, tag/index addressing and victim write-back addressing.
- Sits between the CPU-side request interface and the shared snooping bus.
- Processes one CPU request or one bus snoop per clock.

---
 rtl/sm_cache_mesi_if.sv | 49 ++++
 rtl/sm_cache_mesi.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sm_cache_mesi_if.sv
// sm_cache_mesi_if: CPU-side and snooping-bus signals of one MESI cache
// controller, grouped into a single bundle.
//   slave  modport: the cache controller (sm_cache_mesi)
//   master modport: the CPU / bus side driving requests and snoops
// Signals:
//   cpuReq/cpuWrite/cpuAddr        CPU request, held until cpuDone
//   busReq/busOp/busAddr/sharedIn  snoop request and shared-line input
//   cpuDone/hit                    request completion pulses
//   busValid/busCmd/busAddrOut     issued bus command
//   writeBack/wbAddr               dirty block write-back
//   sharedOut                      snoop hit indication
//   lineStates                     flattened MESI state, line i at [2i+1:2i]
interface sm_cache_mesi_if #(
    parameter int LINES = 4,
    parameter int TAG_W = 4
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int ADDR_W = TAG_W + IDX_W;

    logic              cpuReq;
    logic              cpuWrite;
    logic [ADDR_W-1:0] cpuAddr;
    logic              busReq;
    logic [1:0]        busOp;
    logic [ADDR_W-1:0] busAddr;
    logic              sharedIn;

    logic              cpuDone;
    logic              hit;
    logic              busValid;
    logic [1:0]        busCmd;
    logic [ADDR_W-1:0] busAddrOut;
    logic              writeBack;
    logic [ADDR_W-1:0] wbAddr;
    logic              sharedOut;
    logic [2*LINES-1:0] lineStates;

    modport slave (
        input  cpuReq, cpuWrite, cpuAddr, busReq, busOp, busAddr, sharedIn,
        output cpuDone, hit, busValid, busCmd, busAddrOut, writeBack, wbAddr,
               sharedOut, lineStates
    );

    modport master (
        output cpuReq, cpuWrite, cpuAddr, busReq, busOp, busAddr, sharedIn,
        input  cpuDone, hit, busValid, busCmd, busAddrOut, writeBack, wbAddr,
               sharedOut, lineStates
    );
endinterface

// File: rtl/sm_cache_mesi.sv
// sm_cache_mesi: per-cache MESI coherence controller for a direct-mapped
// array of LINES lines, each holding a tag and a MESI state.
// Ports:
//   clock   rising-edge clock
//   resetN  synchronous active-low reset
//   bus     sm_cache_mesi_if.slave: CPU request side, snoop side and all
//           registered outputs (completion, bus command, write-back,
//           sharedOut, flattened line states)
// One CPU request or one snoop is handled per clock; a snoop always wins
// and stalls the CPU for that cycle.
module sm_cache_mesi #(
    parameter int LINES = 4,
    parameter int TAG_W = 4
) (
    input  logic           clock,
    input  logic           resetN,
    sm_cache_mesi_if.slave bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_M = 2'b10,
        ST_E = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        OP_READ_MISS  = 2'b00,
        OP_WRITE_MISS = 2'b01,
        OP_INVALIDATE = 2'b10,
        OP_RESERVED   = 2'b11
    } busop_t;

    mesi_t            st  [LINES];
    logic [TAG_W-1:0] tag [LINES];

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] snp_idx;
    logic [TAG_W-1:0] snp_tag;
    logic             cpu_hit;
    logic             snp_hit;
    busop_t           snp_op;

    always_comb begin
        cpu_idx = bus.cpuAddr[IDX_W-1:0];
        cpu_tag = bus.cpuAddr[ADDR_W-1:IDX_W];
        snp_idx = bus.busAddr[IDX_W-1:0];
        snp_tag = bus.busAddr[ADDR_W-1:IDX_W];
        snp_op  = busop_t'(bus.busOp);
        cpu_hit = (st[cpu_idx] != ST_I) && (tag[cpu_idx] == cpu_tag);
        snp_hit = (st[snp_idx] != ST_I) && (tag[snp_idx] == snp_tag);
    end

    always_comb begin
        bus.lineStates = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            bus.lineStates[2*i +: 2] = st[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                st[i]  <= ST_I;
                tag[i] <= '0;
            end
            bus.cpuDone    <= 1'b0;
            bus.hit        <= 1'b0;
            bus.busValid   <= 1'b0;
            bus.busCmd     <= '0;
            bus.busAddrOut <= '0;
            bus.writeBack  <= 1'b0;
            bus.wbAddr     <= '0;
            bus.sharedOut  <= 1'b0;
        end else begin
            bus.cpuDone   <= 1'b0;
            bus.hit       <= 1'b0;
            bus.busValid  <= 1'b0;
            bus.writeBack <= 1'b0;
            bus.sharedOut <= 1'b0;

            if (bus.busReq) begin
                // Snoop has priority; the CPU request stays pending and is
                // re-evaluated against the updated line next cycle.
                if (snp_hit && snp_op != OP_RESERVED) begin
                    if (st[snp_idx] == ST_M) begin
                        bus.writeBack <= 1'b1;
                        bus.wbAddr    <= bus.busAddr;
                    end
                    if (snp_op == OP_READ_MISS) begin
                        bus.sharedOut <= 1'b1;
                        st[snp_idx]   <= ST_S;
                    end else begin
                        st[snp_idx]   <= ST_I;
                    end
                end
            end else if (bus.cpuReq) begin
                bus.cpuDone <= 1'b1;
                bus.hit     <= cpu_hit;
                if (cpu_hit) begin
                    if (bus.cpuWrite) begin
                        // Only a shared copy needs to invalidate the others.
                        if (st[cpu_idx] == ST_S) begin
                            bus.busValid   <= 1'b1;
                            bus.busCmd     <= OP_INVALIDATE;
                            bus.busAddrOut <= bus.cpuAddr;
                        end
                        st[cpu_idx] <= ST_M;
                    end
                end else begin
                    if (st[cpu_idx] == ST_M) begin
                        bus.writeBack <= 1'b1;
                        bus.wbAddr    <= {tag[cpu_idx], cpu_idx};
                    end
                    bus.busValid   <= 1'b1;
                    bus.busCmd     <= bus.cpuWrite ? OP_WRITE_MISS : OP_READ_MISS;
                    bus.busAddrOut <= bus.cpuAddr;
                    tag[cpu_idx]   <= cpu_tag;
                    if (bus.cpuWrite)
                        st[cpu_idx] <= ST_M;
                    else
                        st[cpu_idx] <= bus.sharedIn ? ST_S : ST_E;
                end
            end
        end
    end
endmodule
